// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer
//   Game sequencer for the three-lane obstacle game. Owns the 6-row x 3-lane
//   obstacle field, produces the field-advance tick with a speed ramp, injects
//   new rows from the pattern generator, detects player/obstacle collisions
//   and runs the IDLE/RUN/HIT/OVER game state machine with lives and score.
//
// Ports
//   clk          system clock, all registers on posedge
//   reset_n      synchronous active-low reset
//   start        start / restart request (honoured in IDLE and OVER)
//   obs_pattern  candidate top row, bit0 = left lane
//   player       one-hot player lane, bit0 = left lane
//   field        obstacle field, [2:0] top row ... [17:15] bottom row
//   tick         one-cycle pulse per field advance period
//   game_active  high in RUN
//   hit_flash    high in HIT
//   game_over    high in OVER
//   score        rows cleared, saturating
//   lives_left   remaining lives
module obstacle_sequencer #(
  parameter int TICK_INIT     = 7897898,
  parameter int TICK_MIN      = 2000000,
  parameter int TICK_DEC      = 500000,
  parameter int SPEEDUP_EVERY = 8,
  parameter int LIVES         = 3,
  parameter int HIT_HOLD      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  obs_pattern,
  input  logic [2:0]  player,
  output logic [17:0] field,
  output logic        tick,
  output logic        game_active,
  output logic        hit_flash,
  output logic        game_over,
  output logic [15:0] score,
  output logic [1:0]  lives_left
);

  typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;

  localparam logic [31:0] PERIOD_INIT = 32'(TICK_INIT);
  localparam logic [31:0] PERIOD_MIN  = 32'(TICK_MIN);
  localparam logic [31:0] PERIOD_DEC  = 32'(TICK_DEC);
  localparam logic [15:0] SPEED_LAST  = 16'(SPEEDUP_EVERY - 1);
  localparam logic [7:0]  HOLD_INIT   = 8'(HIT_HOLD);
  localparam logic [1:0]  LIVES_INIT  = 2'(LIVES);

  state_t      state;
  logic [31:0] period;
  logic [31:0] div_cnt;
  logic [15:0] speed_cnt;
  logic [7:0]  hold_cnt;

  logic [2:0]  player_s;
  logic [2:0]  ins;
  logic        coll;
  logic        wrap;

  // Row selection, player sanitising and collision detection. A non-one-hot
  // player is parked in the middle lane. The new top row is forced blank after
  // an obstacle row, and a full-width pattern gets its left lane opened.
  always_comb begin
    player_s = 3'b010;
    if (player == 3'b001 || player == 3'b010 || player == 3'b100)
      player_s = player;

    ins = obs_pattern;
    if (field[2:0] != 3'b000)
      ins = 3'b000;
    else if (obs_pattern == 3'b111)
      ins = 3'b110;

    coll = (state == RUN) && ((field[17:15] & player_s) != 3'b000);
    wrap = (div_cnt >= period - 32'd1);
  end

  // Game state machine, divider, field and scoring. The divider wrap is the
  // event that registers tick, so the HIT hold count is stepped on the wrap
  // itself; the final wrap of HIT hands straight back to RUN (or OVER) with a
  // fresh divider and no tick, which keeps HIT at exactly HIT_HOLD periods.
  // A collision wins over a coincident tick: the shift and score are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      field      <= '0;
      tick       <= 1'b0;
      score      <= '0;
      lives_left <= LIVES_INIT;
      period     <= PERIOD_INIT;
      div_cnt    <= '0;
      speed_cnt  <= '0;
      hold_cnt   <= '0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (start)
            state <= RUN;
        end

        RUN: begin
          if (coll) begin
            state      <= HIT;
            lives_left <= lives_left - 2'd1;
            field      <= '0;
            hold_cnt   <= HOLD_INIT;
            div_cnt    <= '0;
          end else begin
            if (wrap) begin
              div_cnt <= '0;
              tick    <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 32'd1;
            end

            if (tick) begin
              field <= {field[14:0], ins};
              if (field[17:15] != 3'b000) begin
                if (score != 16'hFFFF)
                  score <= score + 16'd1;
                if (speed_cnt >= SPEED_LAST) begin
                  speed_cnt <= '0;
                  if (period >= PERIOD_MIN + PERIOD_DEC)
                    period <= period - PERIOD_DEC;
                  else
                    period <= PERIOD_MIN;
                end else begin
                  speed_cnt <= speed_cnt + 16'd1;
                end
              end
            end
          end
        end

        HIT: begin
          if (wrap) begin
            div_cnt <= '0;
            if (hold_cnt <= 8'd1) begin
              hold_cnt <= '0;
              state    <= (lives_left != 2'd0) ? RUN : OVER;
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
              tick     <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
        end

        OVER: begin
          div_cnt <= '0;
          if (start) begin
            state      <= RUN;
            field      <= '0;
            score      <= '0;
            lives_left <= LIVES_INIT;
            period     <= PERIOD_INIT;
            speed_cnt  <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Status flags are a direct decode of the state register.
  assign game_active = (state == RUN);
  assign hit_flash   = (state == HIT);
  assign game_over   = (state == OVER);

endmodule
